// File: rtl/mig_seq_eval.sv
// Sequential majority-inverter network evaluator: one shared MAJ3 unit walks a
// loadable node program, one node per cycle. Macro MIG_NODE_VEC_EN adds node_vec.
module mig_seq_eval #(
    parameter int MAX_NODES = 16,
    parameter int SIG_W     = 5,
    parameter int CNT_W     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [CNT_W-1:0]       cfg_addr,
    input  logic [3*(SIG_W+1)-1:0] cfg_data,
    input  logic                   cfg_num_we,
    input  logic [CNT_W-1:0]       cfg_num,
    input  logic                   cfg_out_inv,
    output logic                   cfg_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_val,
`ifdef MIG_NODE_VEC_EN
    output logic [MAX_NODES-1:0]   node_vec,
`endif
    output logic                   out_err
);
    localparam int OW = SIG_W + 1;
    localparam int AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [3*OW-1:0]      prog_r [MAX_NODES];
    logic [MAX_NODES-1:0] res_r;
    logic [1:0]           state_r;
    logic [CNT_W-1:0]     k_r;
    logic [CNT_W-1:0]     num_nodes_r;
    logic                 out_inv_r;
    logic [6:0]           x_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 out_val_r;
    logic                 out_err_r;
    logic                 cfg_err_r;

    logic [AW-1:0]        k_idx_s;
    logic [OW-1:0]        op_a_s, op_b_s, op_c_s;
    logic [1:0]           fa_s, fb_s, fc_s;
    logic                 node_val_s, node_err_s;
    logic                 in_idle_s, accept_s, prog_wr_s, num_wr_s, cfg_rej_s;
    logic [CNT_W-1:0]     num_next_s;
    logic                 inv_next_s;

    // Resolve one operand to {illegal, value}; only nodes already computed this pass are readable.
    function automatic logic [1:0] fetch_operand(
        input logic [OW-1:0]        opnd,
        input logic [6:0]           x,
        input logic [MAX_NODES-1:0] res,
        input logic [CNT_W-1:0]     k
    );
        logic [SIG_W-1:0] idx;
        logic             sig;
        logic             err;
        idx = opnd[SIG_W-1:0];
        sig = 1'b0;
        err = 1'b0;
        if (idx == {SIG_W{1'b0}}) begin
            sig = 1'b0;
        end else if (idx < SIG_W'(4'd8)) begin
            sig = x[idx[2:0] - 3'd1];
        end else if ({1'b0, idx} < (OW'(k) + OW'(4'd8))) begin
            sig = res[AW'(idx - SIG_W'(4'd8))];
        end else begin
            err = 1'b1;
        end
        return {err, sig ^ opnd[SIG_W]};
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Current-node evaluation and config-port decode.
    always_comb begin
        k_idx_s                    = k_r[AW-1:0];
        {op_c_s, op_b_s, op_a_s}   = prog_r[k_idx_s];
        fa_s                       = fetch_operand(op_a_s, x_r, res_r, k_r);
        fb_s                       = fetch_operand(op_b_s, x_r, res_r, k_r);
        fc_s                       = fetch_operand(op_c_s, x_r, res_r, k_r);
        node_val_s                 = maj3(fa_s[0], fb_s[0], fc_s[0]);
        node_err_s                 = fa_s[1] | fb_s[1] | fc_s[1];
        in_idle_s                  = (state_r == IDLE);
        accept_s                   = in_valid && in_ready_r;
        prog_wr_s                  = cfg_we && in_idle_s && (cfg_addr < CNT_W'(MAX_NODES));
        num_wr_s                   = cfg_num_we && in_idle_s;
        cfg_rej_s                  = (cfg_we && !prog_wr_s) ||
                                     (cfg_num_we && (!in_idle_s || (cfg_num > CNT_W'(MAX_NODES))));
        if (num_wr_s) begin
            num_next_s = (cfg_num > CNT_W'(MAX_NODES)) ? CNT_W'(MAX_NODES) : cfg_num;
            inv_next_s = cfg_out_inv;
        end else begin
            num_next_s = num_nodes_r;
            inv_next_s = out_inv_r;
        end
    end

    // Node program storage; deliberately survives reset.
    always_ff @(posedge clk) begin
        if (prog_wr_s) begin
            prog_r[cfg_addr[AW-1:0]] <= cfg_data;
        end
    end

    // Node result file, written as each node is evaluated.
    always_ff @(posedge clk) begin
        if (state_r == EVAL) begin
            res_r[k_idx_s] <= node_val_s;
        end
    end

    // Sequencer: IDLE -> EVAL (one node per cycle) -> DONE until the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= {CNT_W{1'b0}};
            num_nodes_r <= {CNT_W{1'b0}};
            out_inv_r   <= 1'b0;
            x_r         <= 7'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_val_r   <= 1'b0;
            out_err_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_err_r   <= cfg_rej_s;
            num_nodes_r <= num_next_s;
            out_inv_r   <= inv_next_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        x_r        <= in_x;
                        k_r        <= {CNT_W{1'b0}};
                        out_err_r  <= 1'b0;
                        in_ready_r <= 1'b0;
                        if (num_next_s == {CNT_W{1'b0}}) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            out_val_r   <= inv_next_s;
                        end else begin
                            state_r <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    out_err_r <= out_err_r | node_err_s;
                    k_r       <= k_r + CNT_W'(1'b1);
                    if (k_r == (num_nodes_r - CNT_W'(1'b1))) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        out_val_r   <= node_val_s ^ out_inv_r;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

`ifdef MIG_NODE_VEC_EN
    logic [MAX_NODES-1:0] node_vec_r;

    // Per-node result snapshot; nodes beyond num_nodes stay cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            node_vec_r <= {MAX_NODES{1'b0}};
        end else if (in_idle_s && accept_s) begin
            node_vec_r <= {MAX_NODES{1'b0}};
        end else if (state_r == EVAL) begin
            node_vec_r[k_idx_s] <= node_val_s;
        end
    end

    assign node_vec = node_vec_r;
`endif

    assign cfg_err   = cfg_err_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_val   = out_val_r;
    assign out_err   = out_err_r;
endmodule

// File: tb/tb_mig_seq_eval.sv
// Self-checking bench for mig_seq_eval: randomized vectors and programs against a
// behavioural network model, plus stall, reject, reset and boundary scenarios.
module tb_mig_seq_eval;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = 5'd0;
    logic [17:0] cfg_data = 18'd0;
    logic        cfg_num_we = 1'b0;
    logic [4:0]  cfg_num = 5'd0;
    logic        cfg_out_inv = 1'b0;
    logic        cfg_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_x = 7'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_val;
    logic        out_err;
`ifdef MIG_NODE_VEC_EN
    logic [15:0] node_vec;
`endif

    int total = 0;
    int bad   = 0;

    logic [17:0] prog_m [16];
    int          num_m = 0;
    logic        inv_m = 1'b0;

    mig_seq_eval dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_num_we(cfg_num_we), .cfg_num(cfg_num), .cfg_out_inv(cfg_out_inv),
        .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
`ifdef MIG_NODE_VEC_EN
        .node_vec(node_vec),
`endif
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Network model: count ones per node, illegal references read 0 and flag an error.
    function automatic logic [1:0] model_eval(input logic [6:0] x);
        logic nv [16];
        logic err;
        logic s;
        int   ones;
        int   idx;
        err = 1'b0;
        for (int k = 0; k < num_m; k++) begin
            ones = 0;
            for (int o = 0; o < 3; o++) begin
                idx = int'(prog_m[k][o*6 +: 5]);
                if (idx == 0) s = 1'b0;
                else if (idx <= 7) s = x[idx-1];
                else if (idx - 8 < k) s = nv[idx-8];
                else begin s = 1'b0; err = 1'b1; end
                s = s ^ prog_m[k][o*6+5];
                ones += int'(s);
            end
            nv[k] = (ones >= 2);
        end
        if (num_m == 0) return {1'b0, inv_m};
        return {err, nv[num_m-1] ^ inv_m};
    endfunction

    function automatic logic [5:0] op(input logic inv, input int idx);
        return {inv, 5'(idx)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_node(input logic [4:0] a, input logic [17:0] d, output logic e);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        e = cfg_err;
        if (a < 5'd16) prog_m[a[3:0]] = d;
    endtask

    task automatic wr_num(input logic [4:0] n, input logic inv, output logic e);
        cfg_num_we = 1'b1; cfg_num = n; cfg_out_inv = inv;
        tick();
        cfg_num_we = 1'b0;
        e = cfg_err;
        num_m = (int'(n) > 16) ? 16 : int'(n);
        inv_m = inv;
    endtask

    task automatic send_vec(input logic [6:0] x, input bit ack, output int lat,
                            output logic v, output logic e);
        in_valid = 1'b1; in_x = x;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        v = out_val;
        e = out_err;
        if (ack) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic program_basic();
        logic e;
        wr_node(5'd0, {op(0,6), op(0,2), op(0,1)}, e);
        wr_node(5'd1, {op(0,7), op(0,5), op(0,2)}, e);
        wr_node(5'd2, {op(0,8), op(0,5), op(0,4)}, e);
        wr_node(5'd3, {op(0,4), op(0,3), op(0,1)}, e);
        wr_node(5'd4, {op(0,11), op(0,9), op(0,8)}, e);
        wr_node(5'd5, {op(0,12), op(0,10), op(0,3)}, e);
        wr_num(5'd6, 1'b0, e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        num_m = 0; inv_m = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_basic();
        logic [6:0] xs [4] = '{7'h7F, 7'h00, 7'h03, 7'h07};
        logic       ev [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat; logic v, e;
        program_basic();
        for (int i = 0; i < 4; i++) begin
            send_vec(xs[i], 1'b1, lat, v, e);
            total++; if (v !== ev[i]) begin bad++; $display("FAIL basic_val x=%h got=%b exp=%b", xs[i], v, ev[i]); end
            total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_err x=%h got=%b exp=0", xs[i], e); end
            total++; if (lat != 7) begin bad++; $display("FAIL basic_latency x=%h got=%0d exp=7", xs[i], lat); end
        end
    endtask

    task automatic test_stall();
        logic [6:0] x; logic [1:0] exp; int lat; logic v, e;
        x = 7'($urandom);
        exp = model_eval(x);
        send_vec(x, 1'b0, lat, v, e);
        total++; if (v !== exp[0] || lat != 7) begin bad++; $display("FAIL stall_first got=%b/%0d exp=%b/7", v, lat, exp[0]); end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({out_valid, out_val, in_ready} !== {1'b1, exp[0], 1'b0}) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b%b%b exp=1%b0", c, out_valid, out_val, in_ready, exp[0]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_release ready=%b valid=%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_cfg_reject();
        logic [6:0] x; logic [1:0] exp; int n; int lat; logic v, e;
        x = 7'($urandom);
        exp = model_eval(x);
        in_valid = 1'b1; in_x = x;
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = ~prog_m[0];
        tick();
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL reject_eval_pulse got=%b exp=1", cfg_err); end
        tick();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reject_eval_single got=%b exp=0", cfg_err); end
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin tick(); n++; end
        cfg_num_we = 1'b1; cfg_num = 5'd1;
        tick();
        cfg_num_we = 1'b0;
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL reject_done_pulse got=%b exp=1", cfg_err); end
        total++; if (out_valid !== 1'b1 || out_val !== exp[0]) begin bad++; $display("FAIL reject_result valid=%b val=%b exp=1/%b", out_valid, out_val, exp[0]); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send_vec(x, 1'b1, lat, v, e);
        total++; if (v !== exp[0] || lat != 7) begin bad++; $display("FAIL reject_repeat got=%b/%0d exp=%b/7", v, lat, exp[0]); end
        wr_node(5'd16, ~prog_m[0], e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL reject_addr_range got=%b exp=1", e); end
        for (int i = 0; i < 3; i++) begin
            x = 7'($urandom);
            exp = model_eval(x);
            send_vec(x, 1'b1, lat, v, e);
            total++; if ({e, v} !== exp) begin bad++; $display("FAIL reject_after_addr x=%h got=%b%b exp=%b", x, e, v, exp); end
        end
    endtask

    task automatic test_fwd_ref();
        logic [1:0] exp; int lat; logic v, e, ce;
        wr_node(5'd2, {op(0,11), op(0,5), op(0,4)}, ce);
        exp = model_eval(7'h7F);
        send_vec(7'h7F, 1'b1, lat, v, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL fwd_err got=%b exp=1", e); end
        total++; if (v !== exp[0]) begin bad++; $display("FAIL fwd_val got=%b exp=%b", v, exp[0]); end
        total++; if (lat != 7) begin bad++; $display("FAIL fwd_latency got=%0d exp=7", lat); end
        wr_node(5'd2, {op(0,8), op(0,5), op(0,4)}, ce);
    endtask

    task automatic test_random();
        logic [6:0] x; logic [1:0] exp; int lat; logic v, e, ce;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 16; k++) begin
                logic [17:0] d;
                for (int o = 0; o < 3; o++) begin
                    int idx;
                    if ($urandom_range(0, 7) == 0) idx = int'($urandom_range(8 + k, 31));
                    else idx = int'($urandom_range(0, 7 + k));
                    d[o*6 +: 6] = op(1'($urandom_range(0, 1)), idx);
                end
                wr_node(5'(k), d, ce);
            end
            wr_num(5'($urandom_range(1, 16)), 1'($urandom_range(0, 1)), ce);
            for (int i = 0; i < 5; i++) begin
                x = 7'($urandom);
                exp = model_eval(x);
                send_vec(x, 1'b1, lat, v, e);
                total++; if ({e, v} !== exp) begin bad++; $display("FAIL rand_result p=%0d x=%h got=%b%b exp=%b", p, x, e, v, exp); end
                total++; if (lat != num_m + 1) begin bad++; $display("FAIL rand_latency p=%0d got=%0d exp=%0d", p, lat, num_m + 1); end
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [17:0] d; logic inv_n; logic [6:0] x; logic [1:0] exp; int lat;
        d = 18'($urandom); inv_n = 1'($urandom_range(0, 1)); x = 7'($urandom);
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = d;
        cfg_num_we = 1'b1; cfg_num = 5'd1; cfg_out_inv = inv_n;
        in_valid = 1'b1; in_x = x;
        tick();
        cfg_we = 1'b0; cfg_num_we = 1'b0; in_valid = 1'b0;
        prog_m[0] = d; num_m = 1; inv_m = inv_n;
        exp = model_eval(x);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
        total++; if ({out_err, out_val} !== exp) begin bad++; $display("FAIL same_cycle_result got=%b%b exp=%b", out_err, out_val, exp); end
        total++; if (lat != 2) begin bad++; $display("FAIL same_cycle_latency got=%0d exp=2", lat); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_zero_nodes();
        logic [6:0] x; logic [1:0] exp; int lat; logic v, e, ce;
        wr_num(5'd0, 1'b1, ce);
        total++; if (ce !== 1'b0) begin bad++; $display("FAIL zero_cfg_err got=%b exp=0", ce); end
        send_vec(7'($urandom), 1'b1, lat, v, e);
        total++; if (v !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL zero_result got=%b/%b exp=1/0", v, e); end
        total++; if (lat != 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        wr_num(5'd20, 1'b0, ce);
        total++; if (ce !== 1'b1) begin bad++; $display("FAIL clamp_cfg_err got=%b exp=1", ce); end
        x = 7'($urandom);
        exp = model_eval(x);
        send_vec(x, 1'b1, lat, v, e);
        total++; if (lat != 17) begin bad++; $display("FAIL clamp_latency got=%0d exp=17", lat); end
        total++; if ({e, v} !== exp) begin bad++; $display("FAIL clamp_result got=%b%b exp=%b", e, v, exp); end
        wr_num(5'd16, 1'b1, ce);
        total++; if (ce !== 1'b0) begin bad++; $display("FAIL max_cfg_err got=%b exp=0", ce); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] x; logic [1:0] exp; int lat; logic v, e, ce;
        in_valid = 1'b1; in_x = 7'($urandom);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        num_m = 0; inv_m = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0) begin
            bad++; $display("FAIL midreset_state ready=%b valid=%b err=%b exp=1/0/0", in_ready, out_valid, out_err);
        end
        wr_num(5'd6, 1'b0, ce);
        x = 7'($urandom);
        exp = model_eval(x);
        send_vec(x, 1'b1, lat, v, e);
        total++; if ({e, v} !== exp || lat != 7) begin bad++; $display("FAIL midreset_fresh got=%b%b/%0d exp=%b/7", e, v, lat, exp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_cfg_reject();
        test_fwd_ref();
        test_random();
        test_same_cycle();
        test_zero_nodes();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
